// File: rtl/ei_axi4_slave_pkg.sv
// Shared types, response codes and helpers for the AXI4 slave memory responder.
package ei_axi4_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    function automatic int lanes_log2(input int lanes);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < lanes) n = i + 1;
        end
        return n;
    endfunction

    // Burst-level errors that do not depend on the beat address.
    function automatic logic size_burst_err(input logic [2:0] size,
                                            input logic [1:0] burst,
                                            input logic [2:0] max_size);
        return (size > max_size) || (burst == BURST_RSVD);
    endfunction

endpackage

// File: rtl/ei_axi4_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED/INCR/WRAP bursts.
module ei_axi4_addr_gen
    import ei_axi4_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  wrap_err_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] size_bytes;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_size;
    logic [ADDR_WIDTH-1:0] lower;
    logic [2:0]            wrap_shift;

    always_comb begin
        wrap_shift = 3'd0;
        wrap_err_o = 1'b0;
        case (len_i)
            8'd1:    wrap_shift = 3'd1;
            8'd3:    wrap_shift = 3'd2;
            8'd7:    wrap_shift = 3'd3;
            8'd15:   wrap_shift = 3'd4;
            default: wrap_err_o = (burst_i == BURST_WRAP);
        endcase

        size_bytes = ADDR_ONE << size_i;
        aligned    = addr_i & ~(size_bytes - ADDR_ONE);
        incr       = aligned + size_bytes;
        wrap_size  = size_bytes << wrap_shift;
        lower      = addr_i & ~(wrap_size - ADDR_ONE);

        // A WRAP burst with an illegal length is answered with SLVERR and stepped as INCR.
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (!wrap_err_o && (incr == lower + wrap_size)) ? lower : incr;
            default:     next_addr_o = incr;
        endcase
    end

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave responder backed by a byte-addressed memory; one write and one read
// burst in flight, each direction with its own FSM.
module ei_axi4_slave_mem
    import ei_axi4_slave_pkg::*;
#(
    parameter int BUS_WIDTH      = 64,
    parameter int BUS_BYTE_LANES = BUS_WIDTH / 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_DEPTH      = 4096
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [BUS_WIDTH-1:0]      wdata,
    input  logic [BUS_BYTE_LANES-1:0] wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [BUS_WIDTH-1:0]      rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    output w_state_e                  w_state_o,
    output r_state_e                  r_state_o
);

    localparam int LANE_BITS = lanes_log2(BUS_BYTE_LANES);
    localparam int WORDS     = MEM_DEPTH / BUS_BYTE_LANES;
    localparam int WORD_BITS = $clog2(WORDS);
    localparam logic [2:0] MAX_SIZE = 3'(LANE_BITS);

    // A transfer happens on a rising edge where valid and ready are both high; every
    // output here is registered, so valid and payload hold until that edge.

    // MEM_DEPTH is a power of two, so any address bit above the array is out of range.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (LANE_BITS + WORD_BITS)) != '0;
    endfunction

    logic [BUS_WIDTH-1:0] mem_q [WORDS];

    // ---------------- write direction ----------------
    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            aw_len_q, aw_len_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic [7:0]            w_beat_q, w_beat_d;
    logic                  w_over_q, w_over_d;
    logic                  w_err_q, w_err_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_wrap_err;
    logic                  w_oor;
    logic                  w_beat_err;
    logic                  mem_we;

    ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_addr_gen (
        .addr_i      (aw_addr_q),
        .len_i       (aw_len_q),
        .size_i      (aw_size_q),
        .burst_i     (aw_burst_q),
        .next_addr_o (w_next_addr),
        .wrap_err_o  (w_wrap_err)
    );

    always_comb begin
        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_beat_d   = w_beat_q;
        w_over_d   = w_over_q;
        w_err_d    = w_err_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        w_beat_err = 1'b0;
        w_oor      = out_of_range(aw_addr_q);

        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_addr_d  = awaddr;
                    aw_len_d   = awlen;
                    aw_size_d  = awsize;
                    aw_burst_d = awburst;
                    w_beat_d   = 8'd0;
                    w_over_d   = 1'b0;
                    w_err_d    = 1'b0;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    // Early wlast, missing wlast and out-of-range beats all poison bresp.
                    w_beat_err = w_oor
                               | (wlast && (w_beat_q != aw_len_q))
                               | (!wlast && (w_beat_q == aw_len_q));
                    mem_we  = !w_oor && !w_over_q;
                    w_err_d = w_err_q | w_beat_err;
                    if (wlast) begin
                        bresp_d = (w_err_d || w_wrap_err
                                   || size_burst_err(aw_size_q, aw_burst_q, MAX_SIZE))
                                  ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        aw_addr_d = w_next_addr;
                        if (w_beat_q == aw_len_q) w_over_d = 1'b1;
                        else                      w_beat_d = w_beat_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_beat_q   <= '0;
            w_over_q   <= 1'b0;
            w_err_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_beat_q   <= w_beat_d;
            w_over_q   <= w_over_d;
            w_err_q    <= w_err_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Memory has no reset: contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < BUS_BYTE_LANES; i++) begin
                if (wstrb[i]) mem_q[aw_addr_q[LANE_BITS +: WORD_BITS]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read direction ----------------
    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d;
    logic [7:0]            r_beat_q, r_beat_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] r_gen_addr;
    logic [7:0]            r_gen_len;
    logic [2:0]            r_gen_size;
    logic [1:0]            r_gen_burst;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic                  r_wrap_err;
    logic                  rd_load;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_oor;

    // In idle the generator sees the AR payload so beat 0 gets its burst-level error.
    assign r_gen_addr  = (r_state_q == R_IDLE) ? araddr  : ar_addr_q;
    assign r_gen_len   = (r_state_q == R_IDLE) ? arlen   : ar_len_q;
    assign r_gen_size  = (r_state_q == R_IDLE) ? arsize  : ar_size_q;
    assign r_gen_burst = (r_state_q == R_IDLE) ? arburst : ar_burst_q;

    ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_addr_gen (
        .addr_i      (r_gen_addr),
        .len_i       (r_gen_len),
        .size_i      (r_gen_size),
        .burst_i     (r_gen_burst),
        .next_addr_o (r_next_addr),
        .wrap_err_o  (r_wrap_err)
    );

    always_comb begin
        r_state_d  = r_state_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_beat_d   = r_beat_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rd_load    = 1'b0;
        rd_addr    = ar_addr_q;

        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    ar_addr_d  = araddr;
                    ar_len_d   = arlen;
                    ar_size_d  = arsize;
                    ar_burst_d = arburst;
                    r_beat_d   = 8'd0;
                    rd_addr    = araddr;
                    rd_load    = 1'b1;
                    rlast_d    = (arlen == 8'd0);
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        ar_addr_d = r_next_addr;
                        rd_addr   = r_next_addr;
                        rd_load   = 1'b1;
                        r_beat_d  = r_beat_q + 8'd1;
                        rlast_d   = ((r_beat_q + 8'd1) == ar_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        rd_oor = out_of_range(rd_addr);
        if (rd_load) begin
            rdata_d = rd_oor ? '0 : mem_q[rd_addr[LANE_BITS +: WORD_BITS]];
            rresp_d = (rd_oor || r_wrap_err || size_burst_err(r_gen_size, r_gen_burst, MAX_SIZE))
                      ? RESP_SLVERR : RESP_OKAY;
        end

        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_beat_q   <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_beat_q   <= r_beat_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bresp     = bresp_q;
    assign arready   = arready_q;
    assign rvalid    = rvalid_q;
    assign rlast     = rlast_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign w_state_o = w_state_q;
    assign r_state_o = r_state_q;

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Scoreboard bench for ei_axi4_slave_mem: a byte reference memory predicts read data,
// expected B and R results are queued when bursts are driven and popped on response.
module tb_ei_axi4_slave_mem;
    import ei_axi4_slave_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    w_state_e    w_dbg;
    r_state_e    r_dbg;

    ei_axi4_slave_mem dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .w_state_o (w_dbg),
        .r_state_o (r_dbg)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks;
    int          n_errors;
    logic [66:0] exp_q[$];   // {rresp, rlast, rdata}
    logic [1:0]  bexp_q[$];
    logic [7:0]  ref_mem [4096];

    logic [31:0] wa [16];
    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [31:0] ra [16];
    logic        ra_err [16];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input logic [31:0] a);
        logic [63:0] w;
        logic [31:0] base;
        w    = '0;
        base = a & ~32'd7;
        if (base < 32'd4096) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[base + 32'(i)];
        end
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    // Drives AW, nbeats W beats (wlast on last_idx) and collects B; wa/wd/ws hold the beats.
    task automatic drive_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int nbeats, input int last_idx,
                               input logic [1:0] exp_resp);
        int t;
        int nw;
        logic [31:0] base;
        bexp_q.push_back(exp_resp);
        nw = (nbeats < int'(len) + 1) ? nbeats : int'(len) + 1;
        for (int b = 0; b < nw; b++) begin
            base = wa[b] & ~32'd7;
            if (base < 32'd4096) begin
                for (int i = 0; i < 8; i++) if (ws[b][i]) ref_mem[base + 32'(i)] = wd[b][8*i +: 8];
            end
        end

        @(negedge aclk);
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        check_eq("aw_ready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_idx); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(negedge aclk); t++; end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check_eq("b_latency", bvalid, 1);
        check_eq("w_ready_after_last", wready, 0);
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge aclk); t++; end
        check_eq("bresp", bresp, bexp_q.pop_front());
        @(negedge aclk);
        bready = 1'b0;
        check_eq("b_done_valid", bvalid, 0);
        check_eq("aw_ready_after_b", awready, 1);
    endtask

    // Drives AR and consumes len+1 beats; ra/ra_err give each beat's address and error.
    task automatic drive_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int stall_beat);
        int t;
        logic [66:0] e;
        for (int b = 0; b <= int'(len); b++) begin
            exp_q.push_back({ra_err[b] ? RESP_SLVERR : RESP_OKAY, (b == int'(len)),
                             ra_err[b] ? 64'd0 : ref_word(ra[b])});
        end

        @(negedge aclk);
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1; rready = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        check_eq("ar_ready", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
        check_eq("r_first_latency", rvalid, 1);
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!rvalid && t < 50) begin @(negedge aclk); t++; end
            e = exp_q.pop_front();
            check_eq("rvalid", rvalid, 1);
            check_eq("rdata", rdata, e[63:0]);
            check_eq("rresp", rresp, e[66:65]);
            check_eq("rlast", rlast, e[64]);
            if (b == stall_beat) begin
                rready = 1'b0;
                repeat (5) begin
                    @(negedge aclk);
                    check_eq("rdata_hold", rdata, e[63:0]);
                    check_eq("rresp_hold", rresp, e[66:65]);
                    check_eq("rlast_hold", rlast, e[64]);
                end
                rready = 1'b1;
            end
            @(negedge aclk);
        end
        rready = 1'b0;
        check_eq("r_end_valid", rvalid, 0);
        check_eq("r_end_last", rlast, 0);
        check_eq("r_end_arready", arready, 1);
    endtask

    task automatic write_incr(input logic [31:0] addr, input logic [7:0] len);
        for (int b = 0; b <= int'(len); b++) begin
            wa[b] = addr + 32'(8 * b);
            wd[b] = {$urandom, $urandom};
            ws[b] = 8'hFF;
        end
        drive_write(addr, len, 3'd3, BURST_INCR, int'(len) + 1, int'(len), RESP_OKAY);
    endtask

    task automatic read_incr(input logic [31:0] addr, input logic [7:0] len);
        for (int b = 0; b <= int'(len); b++) begin
            ra[b]     = addr + 32'(8 * b);
            ra_err[b] = 1'b0;
        end
        drive_read(addr, len, 3'd3, BURST_INCR, -1);
    endtask

    // ---------------- main sequence ----------------
    int t;

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        aresetn = 1'b0;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset: nothing valid or ready while held.
        repeat (3) begin
            @(negedge aclk);
            check_eq("rst_bvalid", bvalid, 0);
            check_eq("rst_rvalid", rvalid, 0);
            check_eq("rst_awready", awready, 0);
            check_eq("rst_arready", arready, 0);
        end
        aresetn = 1'b1;
        #1;
        check_eq("rel_awready_early", awready, 0);
        @(negedge aclk);
        check_eq("rel_awready", awready, 1);
        check_eq("rel_arready", arready, 1);
        check_eq("rel_rdata", rdata, 0);
        check_eq("rel_rlast", rlast, 0);
        check_eq("rel_bresp", bresp, 0);
        check_eq("rel_wstate", w_dbg, W_IDLE);

        // INCR write of 0x11..0x44 and read back.
        for (int b = 0; b < 4; b++) begin
            wa[b] = 32'h100 + 32'(8 * b);
            wd[b] = {8{8'(8'h11 * (b + 1))}};
            ws[b] = 8'hFF;
        end
        drive_write(32'h100, 8'd3, 3'd3, BURST_INCR, 4, 3, RESP_OKAY);
        read_incr(32'h100, 8'd3);

        // WRAP read from 0x38 wraps inside the 32-byte window at 0x20.
        write_incr(32'h20, 8'd3);
        ra[0] = 32'h38; ra[1] = 32'h20; ra[2] = 32'h28; ra[3] = 32'h30;
        for (int b = 0; b < 4; b++) ra_err[b] = 1'b0;
        drive_read(32'h38, 8'd3, 3'd3, BURST_WRAP, -1);

        // Narrow byte writes at 0x203 and 0x204 touch only those bytes.
        write_incr(32'h200, 8'd0);
        wa[0] = 32'h203; wd[0] = {$urandom, $urandom}; ws[0] = 8'h08;
        wa[1] = 32'h204; wd[1] = {$urandom, $urandom}; ws[1] = 8'h10;
        drive_write(32'h203, 8'd1, 3'd0, BURST_INCR, 2, 1, RESP_OKAY);
        read_incr(32'h200, 8'd0);

        // Out-of-range second beat, with the response stalled for 5 cycles.
        write_incr(32'hFF8, 8'd0);
        ra[0] = 32'hFF8;  ra_err[0] = 1'b0;
        ra[1] = 32'h1000; ra_err[1] = 1'b1;
        drive_read(32'hFF8, 8'd1, 3'd3, BURST_INCR, 1);

        // Early wlast on beat 1 of a 4-beat burst.
        for (int b = 0; b < 2; b++) begin
            wa[b] = 32'h300 + 32'(8 * b);
            wd[b] = {$urandom, $urandom};
            ws[b] = 8'hFF;
        end
        drive_write(32'h300, 8'd3, 3'd3, BURST_INCR, 2, 1, RESP_SLVERR);
        read_incr(32'h300, 8'd1);

        // Missing wlast: beats past len are absorbed without writing.
        write_incr(32'h400, 8'd3);
        for (int b = 0; b < 4; b++) begin
            wa[b] = 32'h400 + 32'(8 * b);
            wd[b] = {$urandom, $urandom};
            ws[b] = 8'hFF;
        end
        drive_write(32'h400, 8'd1, 3'd3, BURST_INCR, 4, 3, RESP_SLVERR);
        read_incr(32'h400, 8'd3);

        // Reset during W_DATA: beat 0 stays written, no B is ever issued.
        @(negedge aclk);
        awaddr = 32'h500; awlen = 8'd3; awsize = 3'd3; awburst = BURST_INCR; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        check_eq("mid_aw_ready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        wd[0] = {$urandom, $urandom};
        wdata = wd[0]; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
        t = 0;
        while (!wready && t < 50) begin @(negedge aclk); t++; end
        check_eq("mid_w_ready", wready, 1);
        @(negedge aclk);
        wvalid = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[32'h500 + i] = wd[0][8*i +: 8];
        aresetn = 1'b0;
        #1;
        check_eq("mid_rst_wready", wready, 0);
        check_eq("mid_rst_bvalid", bvalid, 0);
        check_eq("mid_rst_awready", awready, 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check_eq("mid_rel_awready", awready, 1);
        repeat (3) begin
            check_eq("mid_no_b", bvalid, 0);
            @(negedge aclk);
        end
        read_incr(32'h500, 8'd0);

        repeat (2) @(negedge aclk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
